// File: rtl/bitonic_sorter_pkg.sv
// rtl/bitonic_sorter_pkg.sv - shared sizes and (k,j) stage table for the 8-element bitonic sorter
package bitonic_sorter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int N_ELEMS   = 8;
  localparam int LOG2N     = 3;
  localparam int STAGES    = 6;

  // Stage s of the network runs with block size k and pair distance j.
  function automatic int stage_k(input int s);
    case (s)
      0:       return 2;
      1, 2:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int stage_j(input int s);
    case (s)
      0, 2, 5: return 1;
      1, 4:    return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/bitonic_sorter_cas.sv
// rtl/bitonic_sorter_cas.sv - combinational compare-and-exchange; i_dir = 1 puts the smaller value on o_a
module bitonic_cas
  import bitonic_sorter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  logic w_swap;

  // Equal values never swap, in either direction.
  assign w_swap = i_dir ? (i_a > i_b) : (i_a < i_b);
  assign o_a    = w_swap ? i_b : i_a;
  assign o_b    = w_swap ? i_a : i_b;

endmodule

// File: rtl/bitonic_sorter.sv
// rtl/bitonic_sorter.sv - 6-stage pipelined bitonic sorter for 8 unsigned elements
// with a single global advance shared by every stage register.
module bitonic_sorter
  import bitonic_sorter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = N_ELEMS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_desc,
  input  logic [N*WIDTH-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] data_out
);

  if (N != N_ELEMS || STAGES != LOG2N * (LOG2N + 1) / 2) begin : g_bad_cfg
    $error("bitonic_sorter supports N = 8 only");
  end

  logic [STAGES-1:0]  r_valid;
  logic [STAGES-1:0]  r_desc;
  logic [N*WIDTH-1:0] r_data [STAGES];
  logic [N*WIDTH-1:0] w_net  [STAGES];
  logic               w_adv;

  assign w_adv     = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[STAGES-1];
  assign data_out  = r_data[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int K = stage_k(s);
    localparam int J = stage_j(s);

    logic [N-1:0][WIDTH-1:0] w_in;
    logic [N-1:0][WIDTH-1:0] w_out;
    logic                    w_desc;

    if (s == 0) begin : g_src
      assign w_in   = data_in;
      assign w_desc = in_desc;
    end else begin : g_src
      assign w_in   = r_data[s-1];
      assign w_desc = r_desc[s-1];
    end

    // Pair p maps to the p-th lower index i (bit j clear) and its partner i + j.
    for (genvar p = 0; p < N / 2; p++) begin : g_pair
      localparam int   LO       = (p / J) * 2 * J + (p % J);
      localparam int   HI       = LO + J;
      localparam logic BASE_ASC = ((LO & K) == 0);

      bitonic_cas #(.WIDTH(WIDTH)) u_cas (
        .i_dir (BASE_ASC ^ w_desc),
        .i_a   (w_in[LO]),
        .i_b   (w_in[HI]),
        .o_a   (w_out[LO]),
        .o_b   (w_out[HI])
      );
    end

    assign w_net[s] = w_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_desc  <= '0;
      for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
    end else if (w_adv) begin
      r_valid <= {r_valid[STAGES-2:0], in_valid};
      r_desc  <= {r_desc[STAGES-2:0], in_desc};
      for (int s = 0; s < STAGES; s++) r_data[s] <= w_net[s];
    end
  end

endmodule

// File: tb/tb_bitonic_sorter.sv
// tb/tb_bitonic_sorter.sv - bench for bitonic_sorter: directed and random vectors against a software sort
module tb_bitonic_sorter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_desc, out_valid, out_ready;
  logic [63:0]  data_in, data_out;
  logic         in_valid16, in_ready16, in_desc16, out_valid16, out_ready16;
  logic [127:0] data_in16, data_out16;

  int           n_chk = 0;
  int           n_err = 0;
  int           n_in  = 0;
  int           n_out = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  last_out;
  logic         ov_seen;

  always #5 clk = ~clk;

  bitonic_sorter #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  bitonic_sorter #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_desc(in_desc16),
    .data_in(data_in16), .out_valid(out_valid16), .out_ready(out_ready16), .data_out(data_out16)
  );

  function automatic logic [127:0] ref_sort(input logic [127:0] v, input int w, input logic desc);
    int unsigned e[8];
    int unsigned tmp;
    logic [127:0] r;
    for (int i = 0; i < 8; i++) e[i] = 32'((v >> (i * w)) & ((128'd1 << w) - 1));
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 7 - a; b++)
        if (desc ? (e[b] < e[b+1]) : (e[b] > e[b+1])) begin
          tmp = e[b]; e[b] = e[b+1]; e[b+1] = tmp;
        end
    r = '0;
    for (int i = 0; i < 8; i++) r = r | (128'(e[i]) << (i * w));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle on the 8-bit sorter: drive at the falling edge, score what the rising edge will transfer.
  task automatic tick(input logic v, input logic d, input logic [63:0] x, input logic ordy);
    @(negedge clk);
    in_valid = v; in_desc = d; data_in = x; out_ready = ordy;
    #1;
    ov_seen = out_valid;
    if (out_valid && out_ready) begin
      n_out++;
      last_out = data_out;
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else                   chk("sorted_vector", data_out, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(64'(ref_sort(x, 8, d)));
      n_in++;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick(1'b0, 1'b0, 64'd0, 1'b1);
      lat++;
    end while (!ov_seen && lat < 20);
  endtask

  task automatic run16(input logic [127:0] x, input logic d, output int lat);
    @(negedge clk);
    in_valid16 = 1'b1; in_desc16 = d; data_in16 = x;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid16 = 1'b0;
      lat++;
    end while (!out_valid16 && lat < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks so far %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          out_before;
    logic [21:0] vhist;
    logic [21:0] exp_hist;
    logic [63:0] held;
    logic [127:0] v16;

    rst_n = 1'b0; in_valid = 1'b0; in_desc = 1'b0; data_in = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_desc16 = 1'b0; data_in16 = '0; out_ready16 = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_data_out", data_out, 64'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reversed ramp, ascending then descending.
    tick(1'b1, 1'b0, 64'h0001020304050607, 1'b1);
    wait_out(lat);
    chk("latency_asc", lat, 6);
    chk("ramp_ascending", last_out, 64'h0706050403020100);
    tick(1'b1, 1'b1, 64'h0001020304050607, 1'b1);
    wait_out(lat);
    chk("latency_desc", lat, 6);
    chk("ramp_descending", last_out, 64'h0001020304050607);
    tick(1'b1, 1'b0, 64'h0101808000FF00FF, 1'b1);
    wait_out(lat);
    chk("duplicates_ascending", last_out, 64'hFFFF808001010000);

    // Eight back-to-back random vectors with alternating direction.
    vhist = '0;
    for (int t = 0; t < 22; t++) begin
      if (t < 8) tick(1'b1, t[0], {$urandom(), $urandom()}, 1'b1);
      else       tick(1'b0, 1'b0, 64'd0, 1'b1);
      vhist[t] = ov_seen;
    end
    exp_hist = 22'hFF << 6;
    chk("back_to_back_valid_run", vhist, exp_hist);

    // Fill the pipe, then stall the output for ten cycles.
    for (int t = 0; t < 6; t++) tick(1'b1, $urandom_range(1, 0) == 1, {$urandom(), $urandom()}, 1'b1);
    for (int t = 0; t < 10; t++) begin
      tick(1'b1, 1'b0, {$urandom(), $urandom()}, 1'b0);
      if (t == 0) held = data_out;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_data_hold", data_out, held);
    end
    for (int t = 0; t < 20; t++) tick(1'b0, 1'b0, 64'd0, 1'b1);
    chk("stall_no_loss_count", n_out, n_in);
    chk("stall_queue_drained", exp_q.size(), 0);

    // Reset with three vectors in flight, one of them stalled at the output.
    for (int t = 0; t < 3; t++) tick(1'b1, t[0], {$urandom(), $urandom()}, 1'b1);
    for (int t = 0; t < 8; t++) tick(1'b0, 1'b0, 64'd0, 1'b0);
    chk("pre_reset_out_valid", out_valid, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 1'b0);
    chk("async_reset_data_out", data_out, 64'd0);
    chk("async_reset_in_ready", in_ready, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("in_ready_during_reset", in_ready, 1'b1);
    rst_n = 1'b1;
    out_before = n_out;
    for (int t = 0; t < 15; t++) tick(1'b0, 1'b0, 64'd0, 1'b1);
    chk("no_output_after_reset", n_out, out_before);

    // 16-bit instance: top-bit values must order as unsigned.
    v16 = 128'h0001_8000_FFFE_0000_7FFF_8001_8000_FFFF;
    run16(v16, 1'b0, lat);
    chk("w16_latency", lat, 6);
    chk("w16_unsigned_asc", data_out16, 128'hFFFF_FFFE_8001_8000_8000_7FFF_0001_0000);
    run16(v16, 1'b1, lat);
    chk("w16_unsigned_desc", data_out16, ref_sort(v16, 16, 1'b1));
    v16 = {$urandom(), $urandom(), $urandom(), $urandom()};
    v16[15:0] = 16'hFFFF;
    v16[31:16] = 16'h8000;
    run16(v16, 1'b0, lat);
    chk("w16_random_asc", data_out16, ref_sort(v16, 16, 1'b0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
